// File: rtl/aes_round_engine.sv
// rtl/aes_round_engine.sv - iterative AES-128 encryptor fed by an external round-key generator.
// Define AES_ABORT_EN to add the abort input that cancels a block in flight.

module aes_sbox (
    input  logic [7:0] val,
    output logic [7:0] sub
);
    localparam logic [7:0] AFFINE_C = 8'h63;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] p2, p4, p8, p16, p32, p64, p128, inv;

    // Multiplicative inverse as val^254 = product of val^(2^k), k = 1..7; maps 0 to 0.
    always_comb begin
        p2   = gf_mul(val, val);
        p4   = gf_mul(p2, p2);
        p8   = gf_mul(p4, p4);
        p16  = gf_mul(p8, p8);
        p32  = gf_mul(p16, p16);
        p64  = gf_mul(p32, p32);
        p128 = gf_mul(p64, p64);
        inv  = gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                      gf_mul(gf_mul(p32, p64), p128));
    end

    always_comb begin
        sub = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sub[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                   ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ AFFINE_C[i];
        end
    end
endmodule

module aes_round_engine #(
    parameter int KEY_LAT = 2
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         data_load,
`ifdef AES_ABORT_EN
    input  logic         abort,
`endif
    input  logic [127:0] rx_data,
    input  logic [127:0] orig_key,
    input  logic [127:0] cur_key,
    output logic [3:0]   cur_round,
    output logic [127:0] tx_data,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ROUND, S_DONE} state_t;

    localparam logic [2:0] CNT_LAST = 3'(KEY_LAT - 1);
    localparam logic [3:0] LAST_ROUND = 4'd10;

    state_t         state, state_n;
    logic [127:0]   state_reg, state_reg_n, tx_n, round_out;
    logic [3:0]     cur_round_n;
    logic [2:0]     cnt, cnt_n;
    logic           busy_n, done_n;
    logic [15:0][7:0] sb, sr, mc;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the block sits at [127-8i -: 8]; byte index = row + 4*column.
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .val (state_reg[127 - 8*i -: 8]),
            .sub (sb[i])
        );
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc[4*c]     = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c + 1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c + 2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c + 3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
    end

    // The final round skips MixColumns.
    always_comb begin
        round_out = '0;
        for (int i = 0; i < 16; i++) begin
            round_out[127 - 8*i -: 8] = ((cur_round == LAST_ROUND) ? sr[i] : mc[i])
                                      ^ cur_key[127 - 8*i -: 8];
        end
    end

    always_comb begin
        state_n     = state;
        state_reg_n = state_reg;
        tx_n        = tx_data;
        cur_round_n = cur_round;
        cnt_n       = cnt;
        case (state)
            S_IDLE, S_DONE: begin
                if (data_load) begin
                    state_reg_n = rx_data ^ orig_key;
                    cur_round_n = 4'd1;
                    cnt_n       = 3'd0;
                    state_n     = S_WAIT;
                end else begin
                    state_n     = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt == CNT_LAST) state_n = S_ROUND;
                else                 cnt_n   = cnt + 3'd1;
            end
            S_ROUND: begin
                state_reg_n = round_out;
                if (cur_round == LAST_ROUND) begin
                    tx_n        = round_out;
                    cur_round_n = 4'd0;
                    state_n     = S_DONE;
                end else begin
                    cur_round_n = cur_round + 4'd1;
                    cnt_n       = 3'd0;
                    state_n     = S_WAIT;
                end
            end
            default: state_n = S_IDLE;
        endcase
`ifdef AES_ABORT_EN
        // Abort wins over a completing round on the same edge.
        if (abort && (state == S_WAIT || state == S_ROUND)) begin
            state_n     = S_IDLE;
            state_reg_n = state_reg;
            tx_n        = tx_data;
            cur_round_n = 4'd0;
            cnt_n       = 3'd0;
        end
`endif
        busy_n = (state_n == S_WAIT) || (state_n == S_ROUND);
        done_n = (state_n == S_DONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= S_IDLE;
            state_reg <= '0;
            tx_data   <= '0;
            cur_round <= 4'd0;
            cnt       <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            state_reg <= state_reg_n;
            tx_data   <= tx_n;
            cur_round <= cur_round_n;
            cnt       <= cnt_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end
endmodule

// File: tb/tb_aes_round_engine.sv
// tb/tb_aes_round_engine.sv - self-checking bench for aes_round_engine at KEY_LAT 1, 2 and 4.

module tb_aes_round_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         n_rst, data_load;
    logic [127:0] rx_data, orig_key;
`ifdef AES_ABORT_EN
    logic         abort;
`endif
    logic [3:0]   cr1, cr2, cr4;
    logic [127:0] ck1, ck2, ck4, tx1, tx2, tx4;
    logic         busy1, busy2, busy4, done1, done2, done4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] rk_g [11];
    logic [127:0] kp1;
    logic [127:0] kp2 [2];
    logic [127:0] kp4 [4];

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;
    vec_t vecs [6];

    aes_round_engine #(.KEY_LAT(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .data_load(data_load),
`ifdef AES_ABORT_EN
        .abort(abort),
`endif
        .rx_data(rx_data), .orig_key(orig_key), .cur_key(ck1),
        .cur_round(cr1), .tx_data(tx1), .busy(busy1), .done(done1));

    aes_round_engine #(.KEY_LAT(2)) dut2 (
        .clk(clk), .n_rst(n_rst), .data_load(data_load),
`ifdef AES_ABORT_EN
        .abort(abort),
`endif
        .rx_data(rx_data), .orig_key(orig_key), .cur_key(ck2),
        .cur_round(cr2), .tx_data(tx2), .busy(busy2), .done(done2));

    aes_round_engine #(.KEY_LAT(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .data_load(data_load),
`ifdef AES_ABORT_EN
        .abort(abort),
`endif
        .rx_data(rx_data), .orig_key(orig_key), .cur_key(ck4),
        .cur_round(cr4), .tx_data(tx4), .busy(busy4), .done(done4));

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] a;
        p = 8'h00;
        a = a_in;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, r, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            r = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sbox_t[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] key, input int rnd);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] k, res;
        k = round_key(key, 0);
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            k = round_key(key, rnd);
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8*i -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // Round-key generator stand-in: registered lookup delayed by KEY_LAT cycles.
    function automatic logic [127:0] gen_key(input logic [3:0] r);
        return (r <= 4'd10) ? rk_g[r] : '0;
    endfunction

    always @(posedge clk) begin
        kp1    <= gen_key(cr1);
        kp2[0] <= gen_key(cr2);
        kp2[1] <= kp2[0];
        kp4[0] <= gen_key(cr4);
        for (int i = 1; i < 4; i++) kp4[i] <= kp4[i-1];
    end
    assign ck1 = kp1;
    assign ck2 = kp2[1];
    assign ck4 = kp4[3];

    task automatic set_key(input logic [127:0] key);
        for (int r = 0; r <= 10; r++) rk_g[r] = round_key(key, r);
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_n(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int exp_round(input int lat, input int n);
        return (n < 10*(lat+1)) ? 1 + n/(lat+1) : 0;
    endfunction

    // Returns just after the accepting edge (edge 0).
    task automatic load(input logic [127:0] key, input logic [127:0] pt);
        @(negedge clk);
        set_key(key);
        orig_key  = key;
        rx_data   = pt;
        data_load = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic release_load();
        @(negedge clk);
        data_load = 1'b0;
        rx_data   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(output int lat, output logic [127:0] ct, output int bcnt);
        lat  = -1;
        ct   = '0;
        bcnt = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done2) begin
                lat = n;
                ct  = tx2;
                break;
            end
            if (busy2) bcnt++;
        end
    endtask

    task automatic wait_round(input logic [3:0] r);
        int found;
        found = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (cr2 == r) begin
                found = 1;
                break;
            end
        end
        check_n("reach_round", found, 1);
    endtask

    initial begin
        int           lat, bcnt, dcnt;
        logic [127:0] ct, prev;

        build_sbox();
        n_rst     = 1'b0;
        data_load = 1'b0;
        rx_data   = '0;
        orig_key  = '0;
`ifdef AES_ABORT_EN
        abort     = 1'b0;
`endif
        set_key('0);
        repeat (3) @(posedge clk);
        #1;
        check_n("reset_cur_round", int'(cr2), 0);
        check("reset_tx_data", tx2, '0);
        check_n("reset_busy", int'(busy2), 0);
        check_n("reset_done", int'(done2), 0);
        @(negedge clk);
        n_rst = 1'b1;

        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        for (int v = 2; v < 6; v++) begin
            vecs[v].key = {$urandom, $urandom, $urandom, $urandom};
            vecs[v].pt  = {$urandom, $urandom, $urandom, $urandom};
            vecs[v].ct  = aes_ref(vecs[v].key, vecs[v].pt);
        end

        // cur_round / done / busy trace for all three latencies at once.
        load(vecs[0].key, vecs[0].pt);
        for (int n = 0; n < 55; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            check_n("trace_round_L1", int'(cr1), exp_round(1, n));
            check_n("trace_round_L2", int'(cr2), exp_round(2, n));
            check_n("trace_round_L4", int'(cr4), exp_round(4, n));
            check_n("trace_done_L1", int'(done1), (n == 20) ? 1 : 0);
            check_n("trace_done_L2", int'(done2), (n == 30) ? 1 : 0);
            check_n("trace_done_L4", int'(done4), (n == 50) ? 1 : 0);
            check_n("trace_busy_L2", int'(busy2), (n < 30) ? 1 : 0);
            @(negedge clk);
            data_load = 1'b0;
        end
        check("trace_ct_L1", tx1, vecs[0].ct);
        check("trace_ct_L2", tx2, vecs[0].ct);
        check("trace_ct_L4", tx4, vecs[0].ct);

        for (int v = 0; v < 6; v++) begin
            load(vecs[v].key, vecs[v].pt);
            check_n("busy_at_start", int'(busy2), 1);
            release_load();
            wait_done(lat, ct, bcnt);
            check_n("latency", lat, 30);
            check("ciphertext", ct, vecs[v].ct);
            check_n("busy_cycles", bcnt + 1, 30);
            check_n("busy_low_at_done", int'(busy2), 0);
            check_n("round_zero_at_done", int'(cr2), 0);
        end

        // Load pulse mid-block is ignored; a load in the DONE cycle is accepted.
        load(vecs[2].key, vecs[2].pt);
        release_load();
        wait_round(4'd5);
        @(negedge clk);
        data_load = 1'b1;
        rx_data   = vecs[3].pt;
        @(negedge clk);
        data_load = 1'b0;
        wait_done(lat, ct, bcnt);
        check("ignored_load_ct", ct, vecs[2].ct);
        set_key(vecs[3].key);
        orig_key  = vecs[3].key;
        rx_data   = vecs[3].pt;
        data_load = 1'b1;
        @(posedge clk);
        #1;
        check_n("accept_in_done_busy", int'(busy2), 1);
        check_n("accept_in_done_round", int'(cr2), 1);
        release_load();
        wait_done(lat, ct, bcnt);
        check_n("back_to_back_latency", lat, 30);
        check("back_to_back_ct", ct, vecs[3].ct);

        // Asynchronous reset during round 6.
        load(vecs[4].key, vecs[4].pt);
        release_load();
        wait_round(4'd6);
        #2;
        n_rst = 1'b0;
        #1;
        check_n("midreset_round", int'(cr2), 0);
        check("midreset_tx", tx2, '0);
        check_n("midreset_busy", int'(busy2), 0);
        check_n("midreset_done", int'(done2), 0);
        @(negedge clk);
        n_rst = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done2) dcnt++;
        end
        check_n("midreset_no_done", dcnt, 0);
        load(vecs[5].key, vecs[5].pt);
        release_load();
        wait_done(lat, ct, bcnt);
        check("after_reset_ct", ct, vecs[5].ct);

`ifdef AES_ABORT_EN
        prev = tx2;
        load(vecs[1].key, vecs[1].pt);
        release_load();
        wait_round(4'd3);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        check_n("abort_busy", int'(busy2), 0);
        check_n("abort_round", int'(cr2), 0);
        check_n("abort_done", int'(done2), 0);
        check("abort_tx_kept", tx2, prev);
        @(negedge clk);
        abort = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done2) dcnt++;
        end
        check_n("abort_no_done", dcnt, 0);
        check("abort_tx_still_kept", tx2, prev);
        @(negedge clk);
        abort = 1'b1;
        load(vecs[1].key, vecs[1].pt);
        abort = 1'b0;
        check_n("abort_idle_ignored", int'(busy2), 1);
        release_load();
        wait_done(lat, ct, bcnt);
        check("abort_idle_ct", ct, vecs[1].ct);
`else
        prev = tx2;
        check("tx_holds_after_done", prev, vecs[5].ct);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
